// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory and its response buffer.
package imem_pkg;

  localparam int IMEM_DATA_W    = 32;
  localparam int RSP_FIFO_DEPTH = 2;

  typedef struct packed {
    logic                   err;
    logic [IMEM_DATA_W-1:0] data;
  } imem_rsp_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Two-entry in-order response FIFO; clear wins over push/pop, push+pop is legal when full.
module imem_rsp_fifo
  import imem_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  imem_rsp_t push_data,
  input  logic      pop,
  input  logic      clear,
  output imem_rsp_t head,
  output logic [1:0] count,
  output logic      full,
  output logic      empty
);

  imem_rsp_t mem [RSP_FIFO_DEPTH];
  logic      wr_ptr;
  logic      rd_ptr;
  logic      do_push;
  logic      do_pop;

  assign full    = (count == 2'(RSP_FIFO_DEPTH));
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage is left unreset; the top gates the head with rsp_valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (clear) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= !wr_ptr;
      if (do_pop)  rd_ptr <= !rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/imem_pipelined.sv
// Synchronous-read instruction memory with valid/ready fetch, buffered responses,
// flush for redirects and a back-door program-load port.
module imem_pipelined
  import imem_pkg::*;
#(
  parameter int    DATA_W    = IMEM_DATA_W,
  parameter int    DEPTH     = 64,
  parameter string INIT_FILE = "memfile.dat",
  localparam int   ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_wdata
);

  // Handshake: a request transfers on any rising edge where req_valid && req_ready,
  // a response transfers where rsp_valid && rsp_ready; neither side may depend on the
  // other raising its signal first, and a held-off response keeps its payload stable.

  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic              err_q;
  logic              inflight;
  logic              rdy_en;
  logic [ADDR_W-1:0] idx;
  logic              req_err;
  logic              prog_ok;
  logic              accept;
  logic              pop;
  logic              push;
  imem_rsp_t         push_rsp;
  imem_rsp_t         head;
  logic [1:0]        count;
  logic              full;
  logic              empty;

  assign idx     = req_addr[ADDR_W+1:2];
  assign req_err = is_misaligned(req_addr) || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
  assign prog_ok = {{(32-ADDR_W){1'b0}}, prog_addr} < 32'(DEPTH);
  assign pop     = rsp_valid && rsp_ready;
  assign accept  = req_valid && req_ready;

  // Occupancy is FIFO entries plus the one read in flight; never more than two.
  assign req_ready = rdy_en &&
                     (flush || pop || !(full || (count == 2'd1 && inflight)));

  // Read-first: a same-edge program write is not visible to this read.
  always_ff @(posedge clk) begin
    if (prog_we && prog_ok)  ram[prog_addr] <= prog_wdata;
    if (accept && !req_err)  rd_q <= ram[idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_en   <= 1'b0;
      inflight <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdy_en   <= 1'b1;
      inflight <= accept;
      if (accept) err_q <= req_err;
    end
  end

  // A flush drops the read in flight; a request accepted alongside it survives.
  assign push          = inflight && !flush;
  assign push_rsp.err  = err_q;
  assign push_rsp.data = err_q ? '0 : rd_q;

  imem_rsp_fifo u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_rsp),
    .pop       (pop),
    .clear     (flush),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign rsp_valid = !empty;
  assign rsp_data  = rsp_valid ? head.data : '0;
  assign rsp_err   = rsp_valid && head.err;

endmodule

// File: tb/tb_imem_pipelined.sv
// Self-checking bench for imem_pipelined: table-driven fetch stream plus hand-built
// sequences for reset, backpressure, flush and program-port ordering.
module tb_imem_pipelined;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              flush;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_wdata;

  imem_pipelined #(.DATA_W(DATA_W), .DEPTH(DEPTH), .INIT_FILE("")) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          n_rsp = 0;
  logic        chk_lat = 1'b0;
  logic [32:0] exp_q[$];
  int          acc_q[$];
  logic [32:0] cur_exp = '0;
  logic        prev_hold = 1'b0;
  logic [32:0] prev_rsp = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // scoreboard: pops compared against the queue, accepts push the driver's expectation
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_hold && rsp_valid)
        check("rsp_hold_stable", {31'd0, rsp_err, rsp_data}, {31'd0, prev_rsp});
      if (rsp_valid && rsp_ready && !flush) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_rsp: got %0h expected none", {rsp_err, rsp_data});
        end else begin
          logic [32:0] e;
          int          c;
          e = exp_q.pop_front();
          c = acc_q.pop_front();
          check("rsp", {31'd0, rsp_err, rsp_data}, {31'd0, e});
          if (chk_lat) check("latency", 64'(cyc - c), 64'd2);
        end
      end
      prev_hold = rsp_valid && !rsp_ready && !flush;
      prev_rsp  = {rsp_err, rsp_data};
      if (flush) begin
        exp_q.delete();
        acc_q.delete();
      end
      if (req_valid && req_ready) begin
        n_acc++;
        exp_q.push_back(cur_exp);
        acc_q.push_back(cyc);
      end
    end
  end

  // driver tasks: entered and left just after a rising edge
  task automatic fetch(input logic [31:0] a, input logic [32:0] e);
    bit got;
    got       = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    cur_exp   = e;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = req_ready;
      @(posedge clk);
      #1;
    end
    if (!got) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  vec_t tbl[8];
  int   n0;
  int   r0;

  initial begin
    tbl[0] = '{32'h0,   32'd0,  1'b0};
    tbl[1] = '{32'h4,   32'd1,  1'b0};
    tbl[2] = '{32'h8,   32'd2,  1'b0};
    tbl[3] = '{32'hC,   32'd3,  1'b0};
    tbl[4] = '{32'h2,   32'd0,  1'b1};
    tbl[5] = '{32'h100, 32'd0,  1'b1};
    tbl[6] = '{32'h4,   32'd1,  1'b0};
    tbl[7] = '{32'hFC,  32'd63, 1'b0};

    // reset with a pending request
    reset_n = 1'b0; req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b0;
    flush = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_data",  64'(rsp_data),  64'd0);
    check("reset_rsp_err",   64'(rsp_err),   64'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset_n   = 1'b1;
    @(negedge clk);
    check("ready_before_edge", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("ready_after_release", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;

    // load RAM[i] = i
    for (int i = 0; i < DEPTH; i++) begin
      prog_we = 1'b1; prog_addr = ADDR_W'(i); prog_wdata = 32'(i);
      @(posedge clk);
      #1;
    end
    prog_we = 1'b0;

    // table stream, back-to-back, with latency tracking
    rsp_ready = 1'b1;
    chk_lat   = 1'b1;
    r0        = n_rsp;
    for (int i = 0; i < 8; i++) fetch(tbl[i].addr, {tbl[i].err, tbl[i].data});
    req_valid = 1'b0;
    drain();
    chk_lat = 1'b0;
    check("stream_rsp_count", 64'(n_rsp - r0), 64'd8);

    // backpressure: only two requests may be outstanding
    rsp_ready = 1'b0;
    n0 = n_acc;
    r0 = n_rsp;
    req_valid = 1'b1;
    repeat (6) begin
      req_addr = 32'(4 * (n_acc - n0));
      cur_exp  = {1'b0, 32'(n_acc - n0)};
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("bp_accepts",   64'(n_acc - n0), 64'd2);
    check("bp_req_ready", 64'(req_ready),  64'd0);
    check("bp_rsp_valid", 64'(rsp_valid),  64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    check("bp_rsp_count", 64'(n_rsp - r0), 64'd2);

    // flush with a full FIFO and a redirect fetch in the same cycle
    rsp_ready = 1'b0;
    r0 = n_rsp;
    fetch(32'h0, {1'b0, 32'd0});
    fetch(32'h4, {1'b0, 32'd1});
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pre_flush_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h10; cur_exp = {1'b0, 32'd4};
    @(negedge clk);
    check("flush_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("post_flush_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drain();
    check("flush_rsp_count", 64'(n_rsp - r0), 64'd1);

    // program write and fetch to the same word in one cycle: old data returned
    prog_we = 1'b1; prog_addr = 6'd3; prog_wdata = 32'hDEADBEEF;
    req_valid = 1'b1; req_addr = 32'hC; cur_exp = {1'b0, 32'd3};
    @(negedge clk);
    check("prog_same_cycle_accept", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    prog_we = 1'b0;
    fetch(32'hC, {1'b0, 32'hDEADBEEF});
    fetch(32'h8, {1'b0, 32'd2});
    fetch(32'h10, {1'b0, 32'd4});
    req_valid = 1'b0;
    drain();

    // random fetches with random consumer stalls
    for (int k = 0; k < 40; k++) begin
      int w;
      w         = $urandom_range(0, DEPTH - 1);
      rsp_ready = 1'($urandom_range(0, 1));
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = 32'(w * 4);
      cur_exp   = {1'b0, (w == 3) ? 32'hDEADBEEF : 32'(w)};
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
